// File: rtl/led_breathe_ctrl.sv
// Breathing-profile duty generator for the PWM LED stage: ramp up, hold, ramp down, hold, repeat.
// Settings arrive through a one-deep shadow register and are applied only at profile boundaries.
module led_breathe_ctrl #(
   parameter int unsigned      DIV_W    = 24,
   parameter logic [7:0]       DEF_MIN  = 8'd0,
   parameter logic [7:0]       DEF_MAX  = 8'd255,
   parameter logic [DIV_W-1:0] DEF_DIV  = 24'd48827,
   parameter logic [7:0]       DEF_HOLD = 8'd0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [7:0]       cfg_min,
   input  logic [7:0]       cfg_max,
   input  logic [DIV_W-1:0] cfg_step_div,
   input  logic [7:0]       cfg_hold,
   output logic [7:0]       pwm_duty,
   output logic [2:0]       state,
   output logic             cycle_done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_UP      = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_DOWN    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [7:0]         duty_r, duty_s;
   logic [7:0]         hold_cnt_r, hold_cnt_s;
   logic               done_r, done_s;
   logic [DIV_W-1:0]   cnt_r, cnt_s;
   logic               tick_s;
   logic               apply_s;
   logic               xfer_s;

   logic [7:0]         act_min_r, act_max_r, act_hold_r;
   logic [DIV_W-1:0]   act_div_r;
   logic [7:0]         sh_min_r, sh_max_r, sh_hold_r;
   logic [DIV_W-1:0]   sh_div_r;
   logic               pending_r;
   logic [7:0]         eff_max_s;
   logic [7:0]         new_min_s;

   assign xfer_s     = cfg_valid && !pending_r;
   assign cfg_ready  = ~pending_r;
   assign pwm_duty   = duty_r;
   assign state      = state_r;
   assign cycle_done = done_r;

   // A min above max collapses the ramp to a constant duty of min.
   assign eff_max_s = (act_max_r > act_min_r) ? act_max_r : act_min_r;
   assign new_min_s = pending_r ? sh_min_r : act_min_r;
   assign tick_s    = (state_r != ST_IDLE) && (cnt_r == act_div_r);

   // Prescaler next count; held at zero while idle or disabled.
   always_comb begin
      cnt_s = cnt_r;
      if (!enable || (state_r == ST_IDLE)) begin
         cnt_s = {DIV_W{1'b0}};
      end else if (tick_s) begin
         cnt_s = {DIV_W{1'b0}};
      end else begin
         cnt_s = cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // Profile FSM next-state, duty and hold-counter logic.
   always_comb begin
      state_s    = state_r;
      duty_s     = duty_r;
      hold_cnt_s = hold_cnt_r;
      done_s     = 1'b0;
      apply_s    = 1'b0;
      if (!enable) begin
         state_s    = ST_IDLE;
         duty_s     = 8'd0;
         hold_cnt_s = 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               apply_s    = pending_r;
               duty_s     = new_min_s;
               hold_cnt_s = 8'd0;
               state_s    = ST_UP;
            end
            ST_UP: begin
               if (tick_s) begin
                  if (duty_r < eff_max_s) begin
                     duty_s = duty_r + 8'd1;
                     if ((duty_r + 8'd1) == eff_max_s) begin
                        state_s = ST_HOLD_HI;
                     end else begin
                        state_s = ST_UP;
                     end
                  end else begin
                     state_s = ST_HOLD_HI;
                  end
               end else begin
                  state_s = ST_UP;
               end
            end
            ST_DOWN: begin
               if (tick_s) begin
                  if (duty_r > act_min_r) begin
                     duty_s = duty_r - 8'd1;
                     if ((duty_r - 8'd1) == act_min_r) begin
                        state_s = ST_HOLD_LO;
                     end else begin
                        state_s = ST_DOWN;
                     end
                  end else begin
                     state_s = ST_HOLD_LO;
                  end
               end else begin
                  state_s = ST_DOWN;
               end
            end
            ST_HOLD_HI, ST_HOLD_LO: begin
               if (tick_s) begin
                  if (hold_cnt_r == act_hold_r) begin
                     hold_cnt_s = 8'd0;
                     if (state_r == ST_HOLD_HI) begin
                        state_s = ST_DOWN;
                     end else begin
                        state_s = ST_UP;
                        done_s  = 1'b1;
                        apply_s = pending_r;
                        duty_s  = new_min_s;
                     end
                  end else begin
                     hold_cnt_s = hold_cnt_r + 8'd1;
                  end
               end else begin
                  hold_cnt_s = hold_cnt_r;
               end
            end
            default: begin
               state_s    = ST_IDLE;
               duty_s     = 8'd0;
               hold_cnt_s = 8'd0;
            end
         endcase
      end
   end

   // Profile state, duty, counters and completion pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         duty_r     <= 8'd0;
         hold_cnt_r <= 8'd0;
         done_r     <= 1'b0;
         cnt_r      <= {DIV_W{1'b0}};
      end else begin
         state_r    <= state_s;
         duty_r     <= duty_s;
         hold_cnt_r <= hold_cnt_s;
         done_r     <= done_s;
         cnt_r      <= cnt_s;
      end
   end

   // Shadow capture and boundary application; transfer and apply never coincide.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         act_min_r  <= DEF_MIN;
         act_max_r  <= DEF_MAX;
         act_div_r  <= DEF_DIV;
         act_hold_r <= DEF_HOLD;
         sh_min_r   <= 8'd0;
         sh_max_r   <= 8'd0;
         sh_div_r   <= {DIV_W{1'b0}};
         sh_hold_r  <= 8'd0;
         pending_r  <= 1'b0;
      end else if (xfer_s) begin
         sh_min_r  <= cfg_min;
         sh_max_r  <= cfg_max;
         sh_div_r  <= cfg_step_div;
         sh_hold_r <= cfg_hold;
         pending_r <= 1'b1;
      end else if (apply_s) begin
         act_min_r  <= sh_min_r;
         act_max_r  <= sh_max_r;
         act_div_r  <= sh_div_r;
         act_hold_r <= sh_hold_r;
         pending_r  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_led_breathe_ctrl.sv
// Directed bench for led_breathe_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_led_breathe_ctrl;

   logic        clock;
   logic        reset_n;
   logic        enable;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_min;
   logic [7:0]  cfg_max;
   logic [23:0] cfg_step_div;
   logic [7:0]  cfg_hold;
   logic [7:0]  pwm_duty;
   logic [2:0]  state;
   logic        cycle_done;

   typedef struct {
      logic [7:0] duty;
      logic [2:0] st;
      logic       done;
      logic       ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_step   = 0;

   led_breathe_ctrl dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_min      (cfg_min),
      .cfg_max      (cfg_max),
      .cfg_step_div (cfg_step_div),
      .cfg_hold     (cfg_hold),
      .pwm_duty     (pwm_duty),
      .state        (state),
      .cycle_done   (cycle_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: every negedge compare DUT outputs with the oldest expectation.
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({pwm_duty, state, cycle_done, cfg_ready} !== {e.duty, e.st, e.done, e.ready}) begin
            n_fail++;
            $display("FAIL cycle%0d: got duty=%0d state=%0d done=%0b ready=%0b, want duty=%0d state=%0d done=%0b ready=%0b",
                     n_checks, pwm_duty, state, cycle_done, cfg_ready, e.duty, e.st, e.done, e.ready);
         end
      end
   end

   // Expect the given outputs in the current cycle, then advance one clock.
   task automatic step(input logic [7:0] d, input logic [2:0] s, input logic dn, input logic rdy);
      exp_t e;
      e.duty  = d;
      e.st    = s;
      e.done  = dn;
      e.ready = rdy;
      exp_q.push_back(e);
      n_step++;
      @(posedge clock);
      #1;
   endtask

   // From IDLE: hand a config to the shadow, then enable so it is applied.
   task automatic load_cfg_idle(input logic [7:0] mn, input logic [7:0] mx,
                                input logic [7:0] hd, input logic [23:0] dv);
      cfg_min      = mn;
      cfg_max      = mx;
      cfg_hold     = hd;
      cfg_step_div = dv;
      cfg_valid    = 1'b1;
      step(8'd0, 3'd0, 1'b0, 1'b1);
      cfg_valid = 1'b0;
      enable    = 1'b1;
      step(8'd0, 3'd0, 1'b0, 1'b0);
   endtask

   // Drop enable in the current cycle; leaves the bench in an IDLE cycle.
   task automatic disable_now(input logic [7:0] d, input logic [2:0] s);
      enable = 1'b0;
      step(d, s, 1'b0, 1'b1);
   endtask

   logic [7:0] basic_duty [12] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd13, 8'd13,
                                   8'd12, 8'd11, 8'd10, 8'd10, 8'd10, 8'd11};
   logic [2:0] basic_st   [12] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                                   3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1};
   logic [7:0] pre_duty   [7]  = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
   logic [2:0] pre_st     [7]  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd1};

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b1;
      cfg_valid    = 1'b0;
      cfg_min      = 8'd0;
      cfg_max      = 8'd0;
      cfg_hold     = 8'd0;
      cfg_step_div = 24'd0;
      @(posedge clock);
      #1;

      // Reset defaults, then release into UP at DEF_MIN with the slow default prescaler.
      step(8'd0, 3'd0, 1'b0, 1'b1);
      step(8'd0, 3'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
      step(8'd0, 3'd0, 1'b0, 1'b1);
      step(8'd0, 3'd1, 1'b0, 1'b1);
      step(8'd0, 3'd1, 1'b0, 1'b1);
      disable_now(8'd0, 3'd1);

      // Basic breathe 10..13, hold 1, tick every clock.
      load_cfg_idle(8'd10, 8'd13, 8'd1, 24'd0);
      for (int i = 0; i < 12; i++) begin
         step(basic_duty[i], basic_st[i], (i == 10) ? 1'b1 : 1'b0, 1'b1);
      end

      // Mid-ramp config is buffered; a second valid while busy is dropped.
      cfg_min = 8'd3; cfg_max = 8'd5; cfg_hold = 8'd0; cfg_step_div = 24'd0;
      cfg_valid = 1'b1;
      step(8'd12, 3'd1, 1'b0, 1'b1);
      cfg_min = 8'd50; cfg_max = 8'd60;
      step(8'd13, 3'd2, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      step(8'd13, 3'd2, 1'b0, 1'b0);
      step(8'd13, 3'd3, 1'b0, 1'b0);
      step(8'd12, 3'd3, 1'b0, 1'b0);
      step(8'd11, 3'd3, 1'b0, 1'b0);
      step(8'd10, 3'd4, 1'b0, 1'b0);
      step(8'd10, 3'd4, 1'b0, 1'b0);
      step(8'd3,  3'd1, 1'b1, 1'b1);
      step(8'd4,  3'd1, 1'b0, 1'b1);
      step(8'd5,  3'd2, 1'b0, 1'b1);
      step(8'd5,  3'd3, 1'b0, 1'b1);
      step(8'd4,  3'd3, 1'b0, 1'b1);
      step(8'd3,  3'd4, 1'b0, 1'b1);
      step(8'd3,  3'd1, 1'b1, 1'b1);
      disable_now(8'd4, 3'd1);

      // Prescaler div=3: each level lasts 4 clocks, cycle_done every 24 clocks.
      load_cfg_idle(8'd0, 8'd2, 8'd0, 24'd3);
      for (int i = 0; i < 28; i++) begin
         step(pre_duty[i / 4], pre_st[i / 4], (i == 24) ? 1'b1 : 1'b0, 1'b1);
      end
      disable_now(8'd1, 3'd1);

      // min>max degenerates to constant min with a 2+2*(hold+1) period.
      load_cfg_idle(8'd200, 8'd100, 8'd1, 24'd0);
      step(8'd200, 3'd1, 1'b0, 1'b1);
      step(8'd200, 3'd2, 1'b0, 1'b1);
      step(8'd200, 3'd2, 1'b0, 1'b1);
      step(8'd200, 3'd3, 1'b0, 1'b1);
      step(8'd200, 3'd4, 1'b0, 1'b1);
      step(8'd200, 3'd4, 1'b0, 1'b1);
      step(8'd200, 3'd1, 1'b1, 1'b1);
      step(8'd200, 3'd2, 1'b0, 1'b1);
      disable_now(8'd200, 3'd2);

      // min=max=255 must never wrap.
      load_cfg_idle(8'd255, 8'd255, 8'd0, 24'd0);
      step(8'd255, 3'd1, 1'b0, 1'b1);
      step(8'd255, 3'd2, 1'b0, 1'b1);
      step(8'd255, 3'd3, 1'b0, 1'b1);
      step(8'd255, 3'd4, 1'b0, 1'b1);
      step(8'd255, 3'd1, 1'b1, 1'b1);
      step(8'd255, 3'd2, 1'b0, 1'b1);
      disable_now(8'd255, 3'd3);

      // Enable drop at duty 7, then restart at min.
      load_cfg_idle(8'd5, 8'd9, 8'd0, 24'd0);
      step(8'd5, 3'd1, 1'b0, 1'b1);
      step(8'd6, 3'd1, 1'b0, 1'b1);
      disable_now(8'd7, 3'd1);
      enable = 1'b1;
      step(8'd0, 3'd0, 1'b0, 1'b1);
      step(8'd5, 3'd1, 1'b0, 1'b1);
      step(8'd6, 3'd1, 1'b0, 1'b1);
      step(8'd7, 3'd1, 1'b0, 1'b1);
      step(8'd8, 3'd1, 1'b0, 1'b1);

      // Reset during HOLD_HI with a pending config: the config must be lost.
      cfg_min = 8'd20; cfg_max = 8'd30; cfg_hold = 8'd0; cfg_step_div = 24'd0;
      cfg_valid = 1'b1;
      step(8'd9, 3'd2, 1'b0, 1'b1);
      cfg_valid = 1'b0;
      reset_n   = 1'b0;
      step(8'd0, 3'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
      step(8'd0, 3'd0, 1'b0, 1'b1);
      step(8'd0, 3'd1, 1'b0, 1'b1);
      step(8'd0, 3'd1, 1'b0, 1'b1);
      enable = 1'b0;

      for (int i = 0; (i < 10) && (exp_q.size() != 0); i++) begin
         @(posedge clock);
      end
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      if (n_checks != n_step) begin
         n_fail++;
         $display("FAIL count: compared %0d, issued %0d", n_checks, n_step);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
